rvc_asap_eot_dumper: RTL
========================

# rvc_asap_eot_dumper

Synthesizable end-of-test engine for the rvc_asap cores. It watches the retiring instruction stream for `ebreak`, with an optional cycle timeout and a software force-dump. On trigger it walks a configurable set of memory regions (for example D_MEM and VGA memory) through a fixed-latency read port and streams every word out over a valid/ready interface. It sits beside the core inside the top level and feeds a UART or FPGA debug sink, so memory snapshots also work on silicon and FPGA, not only in simulation.

## Interface
- NUM_REGIONS, 2: number of memory regions dumped, in index order.
- ADDR_W, 32: address width.
- DATA_W, 32: word width. Must be a multiple of 8.
- REGION_BASE, {32'h0, 32'h0}: packed array [NUM_REGIONS][ADDR_W]. Byte base of each region; word-aligned.
- REGION_WORDS, {32'd1024, 32'd9600}: packed array [NUM_REGIONS][ADDR_W]. Word count per region; 0 means skip.
- TIMEOUT_CYC, 1000000: cycles spent in RUN before a timeout trigger.
- Clock  in  1  core clock.
- Rst_n  in  1  asynchronous, active-low reset.
- InstrValid  in  1  Instr holds a retiring instruction.
- Instr  in  32  retiring instruction.
- ForceDump  in  1  level request to dump now.
- RdReq  out  1  memory read strobe.
- RdAddr  out  ADDR_W  byte address of the read.
- RdData  in  DATA_W  read data, valid exactly one cycle after RdReq.
- OutValid  out  1  stream word valid.
- OutReady  in  1  sink ready.
- OutData  out  DATA_W  dumped word.
- OutAddr  out  ADDR_W  byte address of OutData.
- OutRegion  out  $clog2(NUM_REGIONS)+1  region index of OutData.
- OutLast  out  1  final word of the whole dump.
- Done  out  1  dump complete. Sticky until reset.
- Cause  out  2  0 none, 1 ebreak, 2 timeout, 3 force. Latched at trigger.

## Operation
- States: RUN, REQ, CAPT, SEND, DONE. Reset state is RUN.
- Trigger detection in RUN only:
  - ebreak: InstrValid && Instr==32'h00100073.
  - timeout: timer == TIMEOUT_CYC-1.
  - force: ForceDump.
  - Priority when several fire together: ebreak > timeout > force.
- On trigger:
  - Latch Cause.
  - Select the first region with nonzero REGION_WORDS and go to REQ.
  - If every region is empty, go straight to DONE with no stream output.
- REQ:
  - RdReq=1 and RdAddr=current address for one cycle.
  - Then go to CAPT.
- CAPT:
  - Register RdData, the current address and the region index into the output holding register.
  - Go to SEND.
- SEND:
  - OutValid=1; OutData, OutAddr and OutRegion are held stable until OutReady.
  - On handshake, advance the address by DATA_W/8 and decrement the remaining word count.
  - When the count reaches 0, move to the next non-empty region.
  - After the last region, go to DONE; otherwise go to REQ.
- OutLast=1 only in SEND on the final word of the final non-empty region.
- DONE is terminal: Done=1, and all trigger inputs are ignored.
- Inputs during a dump: ebreak and ForceDump have no effect once the FSM has left RUN.
- Arithmetic width: address and count arithmetic are ADDR_W wide with no saturation. Parameter checks guarantee the region end does not exceed 2^ADDR_W.

## Timing
- Reset values:
  - RdReq=0, RdAddr=0.
  - OutValid=0, OutData=0, OutAddr=0, OutRegion=0, OutLast=0.
  - Done=0, Cause=0.
  - Timer=0.
- Trigger sampled at the posedge ending cycle T:
  - RdReq in T+1.
  - Capture at the end of T+2.
  - OutValid from T+3.
- Per word: a handshake in cycle k gives RdReq in k+1 and the next OutValid in k+2's successor (k+3). Peak rate is one word per 3 cycles.
- Done rises the cycle after the OutLast handshake, or the cycle after the trigger when all regions are empty.
- Timer increments every RUN cycle. A trigger fires TIMEOUT_CYC cycles after reset release with no other trigger.
- Asserting Rst_n low mid-dump clears everything asynchronously, and the block returns to RUN. A partial stream is not resumed.

## Configuration
- RVC_EOT_TIMEOUT_EN defined: the timer is present and timeout triggers as specified.
- RVC_EOT_TIMEOUT_EN undefined: no timer logic; Cause never equals 2; only ebreak and ForceDump trigger.

## Structure
- rvc_asap_pkg holds:
  - t_eot_state enum {RUN, REQ, CAPT, SEND, DONE}.
  - t_eot_cause enum {NONE, EBREAK, TIMEOUT, FORCE}.
  - EBREAK_INSTR = 32'h00100073.
- Sub-module rvc_asap_eot_addr_gen:
  - Holds the region index, current address and remaining count.
  - Provides load-first, advance and region-skip over zero-size regions.
  - Outputs last_word and all_empty flags.
- The top holds the FSM, the timer and the output register.

## Test plan
- ebreak at cycle 50; regions base {0x1000, 0x2000}, words {4, 2}; OutReady=1:
  - Exactly 6 words with OutAddr 0x1000, 0x1004, 0x1008, 0x100C, 0x2000, 0x2004.
  - OutLast only on 0x2004.
  - Cause=1 and Done=1.
- Backpressure:
  - Same setup with OutReady toggling randomly; OutData and OutAddr stay stable while OutValid && !OutReady.
  - No word is dropped or duplicated.
- Timeout with TIMEOUT_CYC=100 and no ebreak:
  - Dump starts with RdReq in cycle 101 after reset release, and Cause=2.
  - With the macro undefined, no dump occurs in 200 cycles.
- ebreak and ForceDump in the same cycle:
  - Cause=1.
  - A second ebreak during SEND leaves Cause and the stream unchanged.
- Zero-size regions with REGION_WORDS={0, 3}:
  - Only region 1 is dumped, and OutRegion=1 on all 3 words.
  - With REGION_WORDS={0, 0}, Done rises the cycle after the trigger and OutValid never rises.
- Reset mid-dump:
  - Rst_n low in SEND of word 2; all outputs return to 0 immediately.
  - A new ebreak after reset restarts the dump from region 0, word 0.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap end-of-test dump engine.
package rvc_asap_pkg;

  typedef enum logic [2:0] {
    RUN,
    REQ,
    CAPT,
    SEND,
    DONE
  } t_eot_state;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EBREAK  = 2'd1,
    TIMEOUT = 2'd2,
    FORCE   = 2'd3
  } t_eot_cause;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/rvc_asap_eot_dumper_if.sv
// Signal bundle of the end-of-test dumper: trigger inputs, memory read port
// and the dumped word stream. master = dumper side, slave = core/memory/sink side.
interface rvc_asap_eot_dumper_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 2
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              force_dump;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [REG_W-1:0]  out_region;
  logic              out_last;
  logic              done;
  logic [1:0]        cause;

  modport master (
    input  instr_valid, instr, force_dump, rd_data, out_ready,
    output rd_req, rd_addr, out_valid, out_data, out_addr, out_region,
           out_last, done, cause
  );

  modport slave (
    output instr_valid, instr, force_dump, rd_data, out_ready,
    input  rd_req, rd_addr, out_valid, out_data, out_addr, out_region,
           out_last, done, cause
  );
endinterface

// File: rtl/rvc_asap_eot_addr_gen.sv
// Region walker for the end-of-test dumper: tracks region index, current byte
// address and words left, skipping regions whose word count is zero.
module rvc_asap_eot_addr_gen #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 2,
  parameter logic [0:NUM_REGIONS-1][ADDR_W-1:0] REGION_BASE  = '0,
  parameter logic [0:NUM_REGIONS-1][ADDR_W-1:0] REGION_WORDS = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [REG_W-1:0]  region,
  output logic [ADDR_W-1:0] addr,
  output logic              last_word,
  output logic              all_empty
);

  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] remaining;

  logic              first_found;
  logic [REG_W-1:0]  first_idx;
  logic [ADDR_W-1:0] first_base;
  logic [ADDR_W-1:0] first_words;
  logic              nxt_found;
  logic [REG_W-1:0]  nxt_idx;
  logic [ADDR_W-1:0] nxt_base;
  logic [ADDR_W-1:0] nxt_words;

  // Find the first non-empty region overall and the first one after the current.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    first_found = 1'b0;
    first_idx   = '0;
    first_base  = '0;
    first_words = '0;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    nxt_base    = '0;
    nxt_words   = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (REGION_WORDS[i] != '0) begin
        first_found = 1'b1;
        first_idx   = REG_W'(i);
        first_base  = REGION_BASE[i];
        first_words = REGION_WORDS[i];
        if (i > int'(region)) begin
          nxt_found = 1'b1;
          nxt_idx   = REG_W'(i);
          nxt_base  = REGION_BASE[i];
          nxt_words = REGION_WORDS[i];
        end
      end
    end
  end

  // Load the first region on trigger, then step word by word and region by region.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      region    <= '0;
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      region    <= first_idx;
      addr      <= first_base;
      remaining <= first_words;
    end else if (advance) begin
      if (remaining > ADDR_W'(1)) begin
        addr      <= addr + BYTES;
        remaining <= remaining - ADDR_W'(1);
      end else if (nxt_found) begin
        region    <= nxt_idx;
        addr      <= nxt_base;
        remaining <= nxt_words;
      end else begin
        remaining <= '0;
      end
    end
  end

  assign last_word = (remaining == ADDR_W'(1)) && !nxt_found;
  assign all_empty = !first_found;

endmodule

// File: rtl/rvc_asap_eot_dumper.sv
// End-of-test dump engine: on ebreak, timeout or force request, walks the
// configured memory regions through a one-cycle-latency read port and
// streams every word out over a valid/ready port.
// Optional feature macro: RVC_EOT_TIMEOUT_EN (cycle-count timeout trigger).
module rvc_asap_eot_dumper
  import rvc_asap_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [0:NUM_REGIONS-1][ADDR_W-1:0] REGION_BASE  = {32'h0, 32'h0},
  parameter logic [0:NUM_REGIONS-1][ADDR_W-1:0] REGION_WORDS = {32'd1024, 32'd9600},
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                  clk,
  input logic                  rst_n,
  rvc_asap_eot_dumper_if.master bus
);

  localparam int REG_W = $clog2(NUM_REGIONS) + 1;
  localparam int BYTES = DATA_W / 8;

  // Elaboration-time parameter sanity checks.
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region_chk
    if ((REGION_BASE[g] & ADDR_W'(BYTES - 1)) != '0) begin : g_align
      $error("REGION_BASE entry is not word aligned");
    end
    if (ADDR_W < 62 && (64'(REGION_BASE[g]) + 64'(REGION_WORDS[g]) * 64'(BYTES))
                       > (64'd1 << ADDR_W)) begin : g_range
      $error("region runs past the end of the address space");
    end
  end

  t_eot_state        state;
  t_eot_cause        cause;
  logic              rd_req;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [REG_W-1:0]  out_region;
  logic              out_last;
  logic              done;

  logic              is_ebreak;
  logic              timeout_hit;
  logic              trigger;
  logic              ag_load;
  logic              ag_advance;
  logic [REG_W-1:0]  ag_region;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last_word;
  logic              ag_all_empty;

  assign is_ebreak = bus.instr_valid && (bus.instr == EBREAK_INSTR);

`ifdef RVC_EOT_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  logic [TIMER_W-1:0] timer;

  // Count cycles spent waiting in RUN; frozen once a dump starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == RUN) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign timeout_hit = (state == RUN) && (timer == TIMER_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign trigger    = is_ebreak || timeout_hit || bus.force_dump;
  assign ag_load    = (state == RUN) && trigger;
  assign ag_advance = (state == SEND) && bus.out_ready;

  rvc_asap_eot_addr_gen #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .REG_W       (REG_W),
    .REGION_BASE (REGION_BASE),
    .REGION_WORDS(REGION_WORDS)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .advance  (ag_advance),
    .region   (ag_region),
    .addr     (ag_addr),
    .last_word(ag_last_word),
    .all_empty(ag_all_empty)
  );

  // Dump sequencer: trigger -> (read request, capture, send) per word -> done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cause      <= NONE;
      rd_req     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_region <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (trigger) begin
            if (is_ebreak)        cause <= EBREAK;
            else if (timeout_hit) cause <= TIMEOUT;
            else                  cause <= FORCE;
            if (ag_all_empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= REQ;
              rd_req <= 1'b1;
            end
          end
        end
        REQ: begin
          rd_req <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          out_data   <= bus.rd_data;
          out_addr   <= ag_addr;
          out_region <= ag_region;
          out_last   <= ag_last_word;
          out_valid  <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= REQ;
              rd_req <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.rd_req     = rd_req;
  assign bus.rd_addr    = ag_addr;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_addr   = out_addr;
  assign bus.out_region = out_region;
  assign bus.out_last   = out_last;
  assign bus.done       = done;
  assign bus.cause      = cause;

endmodule
